// File: rtl/ram_pkg.sv
// Shared definitions for the ram16x4 BIST sequencer.
// Holds default geometry, the state encoding and the march pattern.
package ram_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 4;
    localparam int PAT_MULT = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        R0   = 3'd2,
        W1   = 3'd3,
        R1   = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] a_w;
        logic [DATA_W-1:0] m_w;
        a_w = DATA_W'(a);
        m_w = DATA_W'(PAT_MULT);
        return a_w * m_w;
    endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// March data word for an address, optionally inverted.
// Serves both the write data and the expected read data.
module bist_pattern_gen #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int PAT_MULT = 3
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              inv,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] a_w;
    logic [DATA_W-1:0] m_w;
    logic [DATA_W-1:0] prod;

    // Truncating to DATA_W before multiplying keeps the result mod 2**DATA_W
    assign a_w  = DATA_W'(addr);
    assign m_w  = DATA_W'(PAT_MULT);
    assign prod = a_w * m_w;
    assign data = inv ? ~prod : prod;

endmodule

// File: rtl/ram16x4_bist_ctrl.sv
// Four-phase write/readback march sequencer for ram16x4.
// Reports pass/fail, a saturating error count and the first failure.
module ram16x4_bist_ctrl #(
    parameter int ADDR_W   = ram_pkg::ADDR_W,
    parameter int DATA_W   = ram_pkg::DATA_W,
    parameter int PAT_MULT = ram_pkg::PAT_MULT,
    parameter int ERR_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_phase
);

    import ram_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic              last;
    logic              rd_phase;
    logic              inv;
    logic              mismatch;
    logic              err_sat;
    logic [DATA_W-1:0] pattern;

    bist_pattern_gen #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PAT_MULT(PAT_MULT)
    ) u_pat (
        .addr(ram_addr),
        .inv (inv),
        .data(pattern)
    );

    assign last     = &ram_addr;
    assign ram_we   = (state == W0) || (state == W1);
    assign rd_phase = (state == R0) || (state == R1);
    assign inv      = (state == W1) || (state == R1);
    assign busy     = ram_we || rd_phase;
    assign done     = (state == DONE);
    assign ram_wdata = ram_we ? pattern : '0;
    assign mismatch = rd_phase && (ram_rdata != pattern);
    assign err_sat  = &err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start && !abort) state_nxt = W0;
            W0:   if (abort) state_nxt = IDLE; else if (last) state_nxt = R0;
            R0:   if (abort) state_nxt = IDLE; else if (last) state_nxt = W1;
            W1:   if (abort) state_nxt = IDLE; else if (last) state_nxt = R1;
            R1:   if (abort) state_nxt = IDLE; else if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr        <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_phase <= 1'b0;
        end else begin
            if (state == IDLE && start && !abort) begin
                ram_addr        <= '0;
                pass            <= 1'b0;
                err_count       <= '0;
                first_err_addr  <= '0;
                first_err_phase <= 1'b0;
            end
            if (busy) begin
                if (abort) begin
                    ram_addr <= '0;
                    pass     <= 1'b0;
                end else begin
                    ram_addr <= ram_addr + 1'b1;
                end
                if (mismatch) begin
                    if (!err_sat) err_count <= err_count + 1'b1;
                    if (err_count == '0) begin
                        first_err_addr  <= ram_addr;
                        first_err_phase <= (state == R1);
                    end
                end
                // Final R1 compare lands on the same edge that enters DONE
                if (state == R1 && last && !abort) begin
                    pass <= (err_count == '0) && !mismatch;
                end
            end
            if (state == DONE) ram_addr <= '0;
        end
    end

endmodule
